// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, instruction field offsets, FSM states and decode helper for alu_sequencer
package alu_seq_pkg;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_EQ  = 4'd9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RA_LSB  = 8;
    localparam int RB_LSB  = 0;
    localparam int IMM_LSB = 0;
    typedef enum logic [2:0] {IDLE, ISSUE, CAPT, WB, ERR} state_t;
    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_EQ};
    endfunction
endpackage

// File: rtl/seq_regfile.sv
// seq_regfile: NREGS x DATA_W register file, two async read ports, one sync write port, optional hardwired-zero r0
module seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 4,
    parameter int R0_ZERO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] ra_addr,
    input  logic [$clog2(NREGS)-1:0] rb_addr,
    output logic [DATA_W-1:0]        ra_data,
    output logic [DATA_W-1:0]        rb_data,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic [DATA_W-1:0]        wd
);
    logic [DATA_W-1:0] regs [NREGS];

    // clear on reset; drop writes to r0 when it is hardwired to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && !(R0_ZERO != 0 && wa == '0)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = (R0_ZERO != 0 && ra_addr == '0) ? '0 : regs[ra_addr];
    assign rb_data = (R0_ZERO != 0 && rb_addr == '0) ? '0 : regs[rb_addr];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one instruction at a time to an external combinational ALU and writes results back; ALU_SEQ_FLAGS_EN adds zero/cmp flags
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 4,
    parameter int R0_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [3:0]        alu_inst,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic [DATA_W-1:0] alu_sol,
    output logic              res_valid,
    output logic [1:0]        res_rd,
    output logic [DATA_W-1:0] res_data,
    output logic              err_illegal
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic              zero_flag,
    output logic              cmp_flag
`endif
);
    state_t state, state_n;
    logic [3:0] op_q;
    logic [1:0] rd_q, ra_q, rb_q;
    logic [DATA_W-1:0] result, ra_data, rb_data;
    logic [3:0] op_in;

    assign op_in = instr[OP_LSB +: 4];

    seq_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .R0_ZERO(R0_ZERO)) u_rf (
        .clk(clk), .rst(rst),
        .ra_addr(ra_q), .rb_addr(rb_q),
        .ra_data(ra_data), .rb_data(rb_data),
        .we(state == WB), .wa(rd_q), .wd(result)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // next state: decode at accept, then walk the fixed issue/capture/writeback sequence
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (instr_valid) state_n = is_alu_op(op_in) ? ISSUE : (op_in == OP_LDI) ? WB : ERR;
            ISSUE:   state_n = CAPT;
            CAPT:    state_n = WB;
            default: state_n = IDLE;
        endcase
    end

    assign instr_ready = (state == IDLE);
    assign res_valid   = (state == WB);
    assign err_illegal = (state == ERR);
    assign res_rd      = rd_q;
    assign res_data    = result;

    // latch fields at accept, drive ALU inputs from registers, sample alu_sol only in CAPT
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            result   <= '0;
            alu_inst <= '0;
            alu_op1  <= '0;
            alu_op2  <= '0;
        end else begin
            if (state == IDLE && instr_valid) begin
                op_q   <= op_in;
                rd_q   <= instr[RD_LSB +: 2];
                ra_q   <= instr[RA_LSB +: 2];
                rb_q   <= instr[RB_LSB +: 2];
                result <= (op_in == OP_LDI) ? instr[IMM_LSB +: DATA_W] : result;
            end
            if (state == ISSUE) begin
                alu_inst <= op_q;
                alu_op1  <= ra_data;
                alu_op2  <= rb_data;
            end
            if (state == CAPT) begin
                result   <= alu_sol;
                alu_inst <= '0;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // flags follow writebacks only; cmp tracks EQ results
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag <= 1'b0;
            cmp_flag  <= 1'b0;
        end else if (state == WB) begin
            zero_flag <= (result == '0);
            cmp_flag  <= (op_q == OP_EQ) ? result[0] : cmp_flag;
        end
    end
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with an ALU stand-in and a register-array reference model
module tb_alu_sequencer;
    localparam int R0Z = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [3:0]  alu_inst;
    logic [7:0]  alu_op1, alu_op2, alu_sol;
    logic        res_valid;
    logic [1:0]  res_rd;
    logic [7:0]  res_data;
    logic        err_illegal;
`ifdef ALU_SEQ_FLAGS_EN
    logic        zero_flag, cmp_flag;
`endif

    alu_sequencer #(.DATA_W(8), .NREGS(4), .R0_ZERO(R0Z)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_inst(alu_inst), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sol(alu_sol),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
        .err_illegal(err_illegal)
`ifdef ALU_SEQ_FLAGS_EN
        , .zero_flag(zero_flag), .cmp_flag(cmp_flag)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return ~a;
            4'd7: return (b >= 8) ? 8'h00 : 8'(a << b);
            4'd8: return (b >= 8) ? 8'h00 : (a >> b);
            4'd9: return (a == b) ? 8'h01 : 8'h00;
            default: return 8'hEE;
        endcase
    endfunction

    // ALU stand-in; garbage instead of Z when idle so a stray sample shows up
    assign alu_sol = (alu_inst == 4'd0) ? 8'hEE : alu_f(alu_inst, alu_op1, alu_op2);

    typedef struct {bit err; logic [1:0] rd; logic [7:0] data; int due; bit zf; bit cf;} exp_t;
    typedef struct {int due; logic [3:0] op; logic [7:0] a; logic [7:0] b;} iss_t;
    exp_t exp_q[$];
    iss_t iss_q[$];
    exp_t e;
    iss_t s;
    logic [7:0] mr [4];
    bit mzf = 0, mcf = 0;
    int busy_lo = -10, busy_hi = -10;
    int vectors = 0, miscompares = 0;
    bit started = 0;
    bit pf = 0, pz = 0, pc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [15:0] alu_w(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, 6'b0, rb};
    endfunction

    function automatic logic [15:0] ldi_w(input logic [1:0] rd, input logic [7:0] imm);
        return {4'hA, rd, 2'b0, imm};
    endfunction

    // reference: apply one accepted instruction to the model and queue its expected observations
    task automatic model(input logic [15:0] w, input int acc);
        logic [3:0] op;
        logic [1:0] rd, ra, rb;
        logic [7:0] v;
        bit err;
        int lat;
        op = w[15:12]; rd = w[11:10]; ra = w[9:8]; rb = w[1:0];
        err = 0; lat = 1; v = 8'h00;
        if (op >= 4'd1 && op <= 4'd9) begin
            v = alu_f(op, mr[ra], mr[rb]);
            lat = 3;
            iss_q.push_back('{acc + 2, op, mr[ra], mr[rb]});
        end else if (op == 4'hA) begin
            v = w[7:0];
        end else begin
            err = 1;
        end
        if (!err) begin
            if (!(R0Z != 0 && rd == 2'd0)) mr[rd] = v;
            mzf = (v == 8'h00);
            if (op == 4'd9) mcf = v[0];
        end
        exp_q.push_back('{err, rd, v, acc + lat, mzf, mcf});
        busy_lo = acc;
        busy_hi = acc + lat;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [15:0] w, input bit keep);
        int n;
        instr = w;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (!instr_ready) begin
            check("accept_timeout", instr_ready, 1);
            instr_valid = 1'b0;
        end else begin
            model(w, cyc);
            tick(1);
            if (!keep) instr_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        tick(1);
        exp_q.delete();
        iss_q.delete();
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        mzf = 0; mcf = 0; pf = 0;
        busy_lo = -10; busy_hi = -10;
        rst = 1'b0;
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a result or error pulse
    always @(negedge clk) begin
        if (!rst && started) begin
            check("instr_ready", instr_ready, (cyc > busy_lo && cyc <= busy_hi) ? 0 : 1);
            if (instr_ready) check("alu_inst_idle", alu_inst, 0);
            if (iss_q.size() > 0 && iss_q[0].due <= cyc) begin
                s = iss_q.pop_front();
                check("capt_cycle", cyc, s.due);
                check("alu_inst", alu_inst, s.op);
                check("alu_op1", alu_op1, s.a);
                check("alu_op2", alu_op2, s.b);
            end
`ifdef ALU_SEQ_FLAGS_EN
            if (pf) begin
                check("zero_flag", zero_flag, pz);
                check("cmp_flag", cmp_flag, pc);
                pf = 0;
            end
`endif
            if (res_valid || err_illegal) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {res_valid, err_illegal}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.due);
                    check("err_illegal", err_illegal, e.err);
                    check("res_valid", res_valid, !e.err);
                    if (!e.err) begin
                        check("res_rd", res_rd, e.rd);
                        check("res_data", res_data, e.data);
                    end
                    pf = 1; pz = e.zf; pc = e.cf;
                end
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
                check("missing_pulse", {res_valid, err_illegal}, exp_q[0].err ? 1 : 2);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        tick(2);
        rst = 1'b0;
        check("rst_instr_ready", instr_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_err_illegal", err_illegal, 0);
        check("rst_alu_inst", alu_inst, 0);
        check("rst_alu_op1", alu_op1, 0);
        check("rst_alu_op2", alu_op2, 0);
        check("rst_res_rd", res_rd, 0);
        check("rst_res_data", res_data, 0);
`ifdef ALU_SEQ_FLAGS_EN
        check("rst_zero_flag", zero_flag, 0);
        check("rst_cmp_flag", cmp_flag, 0);
`endif
        started = 1;

        issue(ldi_w(2'd1, 8'h3C), 0);
        issue(ldi_w(2'd2, 8'h05), 0);
        issue(alu_w(4'd1, 2'd3, 2'd1, 2'd2), 0);
        issue(alu_w(4'd2, 2'd0, 2'd2, 2'd1), 0);
        issue(alu_w(4'd9, 2'd0, 2'd1, 2'd1), 0);
        issue(ldi_w(2'd2, 8'h09), 0);
        issue(alu_w(4'd7, 2'd3, 2'd1, 2'd2), 0);
        issue(alu_w(4'd6, 2'd2, 2'd2, 2'd1), 0);
        issue(16'hF5A5, 0);
        issue(16'h0F3C, 0);
        tick(2);
        issue(alu_w(4'd1, 2'd1, 2'd1, 2'd1), 1);
        issue(alu_w(4'd1, 2'd3, 2'd1, 2'd3), 0);
        tick(4);

        issue(alu_w(4'd5, 2'd1, 2'd1, 2'd2), 0);
        do_reset();
        check("ready_after_rst", instr_ready, 1);
        issue(alu_w(4'd4, 2'd1, 2'd1, 2'd2), 0);
        issue(alu_w(4'd4, 2'd2, 2'd3, 2'd0), 0);

        issue(ldi_w(2'd0, 8'hFF), 0);
        issue(alu_w(4'd1, 2'd1, 2'd0, 2'd0), 0);
        tick(4);

        for (int i = 0; i < 250; i++) begin
            logic [15:0] w;
            bit keep;
            w = 16'($urandom);
            keep = 1'($urandom_range(0, 1));
            issue(w, keep);
            if (!keep) tick($urandom_range(0, 2));
        end
        instr_valid = 1'b0;

        n = 0;
        while ((exp_q.size() > 0 || iss_q.size() > 0) && n < 20) begin
            tick(1);
            n++;
        end
        tick(2);
        check("drain_results", exp_q.size(), 0);
        check("drain_issues", iss_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control end of the 8-bit ALU interface: accepts 16-bit instruction words over a valid/ready handshake and reads operands from a 4-entry register file.
- Drives the ALU's inst/operand_1/operand_2 inputs from registers, captures the ALU result and writes it back.
- Sits between instruction fetch and the combinational ALU; one instruction in flight at a time.

Parameters:
- DATA_W, 8, datapath width. Fixed at 8 to match the ALU; any other value is unsupported.
- NREGS, 4, register count. Fixed by the 2-bit register fields.
- R0_ZERO, 0, when 1, r0 always reads 0x00 and writes to r0 are discarded.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  sequencer can accept (IDLE only).
- instr  in  16  [15:12] op, [11:10] rd, [9:8] ra, [1:0] rb, [7:0] imm (LDI only).
- alu_inst  out  4  to ALU inst.
- alu_op1  out  8  to ALU operand_1.
- alu_op2  out  8  to ALU operand_2.
- alu_sol  in  8  from ALU sol.
- res_valid  out  1  one-cycle pulse: writeback occurred.
- res_rd  out  2  destination of the writeback.
- res_data  out  8  value written.
- err_illegal  out  1  one-cycle pulse: illegal opcode consumed.

Behaviour:
- Reset values:
  - State IDLE; all registers 0x00.
  - alu_inst=0, alu_op1=alu_op2=0x00.
  - res_valid=0, res_rd=0, res_data=0x00, err_illegal=0, instr_ready=1.
- Opcodes:
  - 1–9 are ALU ops: ADD, SUB, AND, OR, XOR, NOT, SHL, SHR, EQ.
  - 0xA is LDI: rd <= imm, no ALU use.
  - 0x0 and 0xB–0xF are illegal.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid, latch instr.
    - ALU op -> ISSUE.
    - LDI -> WB.
    - Illegal -> ERR.
  - ISSUE: register alu_inst=op, alu_op1=R[ra], alu_op2=R[rb] (NOT still drives R[rb] on op2). Next -> CAPT.
  - CAPT: ALU inputs stable for one full cycle; sample alu_sol into the result register. -> WB.
  - WB: write R[rd]; assert res_valid/res_rd/res_data for this cycle; restore alu_inst=0. -> IDLE.
  - ERR: pulse err_illegal; no register write, no ALU issue. -> IDLE.
- Latency, counting from the handshake cycle (cycle 0):
  - ALU op: res_valid in cycle 3.
  - LDI: res_valid in cycle 1.
  - Illegal: err_illegal in cycle 1.
- Throughput: instr_ready is low outside IDLE. instr_valid held while busy is not consumed and must remain stable until accepted.
- alu_inst=0 whenever no op is in flight. The ALU then drives Z, so alu_sol must never be sampled outside CAPT.
- Operand hazard: a WB completes before the next IDLE accept, so back-to-back dependent instructions see the written value. No forwarding is needed.
- rd==ra==rb is legal: operands are read in ISSUE, the write happens in WB.
- Width rules: results are 8-bit as delivered by the ALU (SUB wraps mod 256; shift amounts ≥8 give 0x00). No widening or saturation.
- R0_ZERO=1: a write to r0 still pulses res_valid with res_rd=0 and res_data=computed value, but R[0] stays 0x00.
- rst in any state, including mid-operation:
  - Next edge returns to IDLE.
  - All registers clear.
  - No res_valid or err_illegal is produced for the aborted instruction.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- Defined:
  - Adds outputs zero_flag (1) and cmp_flag (1), both reset 0.
  - zero_flag updates on every WB to (res_data==0x00).
  - cmp_flag updates only on EQ writeback, to res_data[0].
  - Flags hold between writebacks; ERR does not change them.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package alu_seq_pkg:
  - Opcode localparams OP_ADD..OP_EQ=1..9, OP_LDI=4'hA.
  - Field offsets for instr.
  - FSM state enum {IDLE, ISSUE, CAPT, WB, ERR}.
  - Helper function is_alu_op(op).
- Sub-module seq_regfile:
  - 4x8 registers, two combinational read ports, one synchronous write port.
  - Synchronous reset clear; honours R0_ZERO.

Test Plan:
- LDI r1,0x3C; LDI r2,0x05; ADD r3,r1,r2 -> res_valid 3 cycles after the ADD accept; res_rd=3, res_data=0x41; alu_inst=1 during CAPT.
- SUB r0,r2,r1 with r1=0x3C, r2=0x05 -> res_data=0xC9 (wrap). EQ r0,r1,r1 -> 0x01. SHL with R[rb]=0x09, R[ra]=0x3C -> 0x00.
- instr op=0xF, then op=0x0 -> err_illegal one cycle each; no res_valid; all registers unchanged; alu_inst stays 0.
- Hold instr_valid=1 with two ADDs queued -> instr_ready low for cycles 1–3 after accept; second ADD accepted only on return to IDLE; exactly two res_valid pulses.
- Assert rst during ISSUE of XOR r1,r1,r2 -> no res_valid; all registers read 0x00 afterward; instr_ready=1 on the cycle after rst deasserts.
- R0_ZERO=1: LDI r0,0xFF -> res_valid with res_data=0xFF; a subsequent ADD r1,r0,r0 yields 0x00. With ALU_SEQ_FLAGS_EN, zero_flag=1 after that ADD.
